// File: rtl/expr_pkg.sv
// Shared class codes, ASCII constants and the head-character classifier
// for the expression recognizer input path.
package expr_pkg;

    typedef logic [2:0] cls_t;

    localparam cls_t CLS_DIGIT = 3'd0;
    localparam cls_t CLS_ADD   = 3'd1;
    localparam cls_t CLS_MUL   = 3'd2;
    localparam cls_t CLS_LPAR  = 3'd3;
    localparam cls_t CLS_RPAR  = 3'd4;
    localparam cls_t CLS_OTHER = 3'd7;

    localparam logic [7:0] ASCII_LPAR  = 8'h28;
    localparam logic [7:0] ASCII_RPAR  = 8'h29;
    localparam logic [7:0] ASCII_ADD   = 8'h2B;
    localparam logic [7:0] ASCII_MUL   = 8'h2A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TAB   = 8'h09;

    function automatic cls_t classify(input logic [7:0] ch);
        cls_t c;
        if ((ch >= ASCII_ZERO) && (ch <= ASCII_NINE)) begin
            c = CLS_DIGIT;
        end else if (ch == ASCII_ADD) begin
            c = CLS_ADD;
        end else if (ch == ASCII_MUL) begin
            c = CLS_MUL;
        end else if (ch == ASCII_LPAR) begin
            c = CLS_LPAR;
        end else if (ch == ASCII_RPAR) begin
            c = CLS_RPAR;
        end else begin
            c = CLS_OTHER;
        end
        return c;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: storage, wrapping pointers and a registered
// occupancy count from which full/not_empty are derived.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              push,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              pop,
    output logic [WIDTH-1:0]  rdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              not_empty
);

    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [ADDR_W-1:0] wptr_r;
    logic [ADDR_W-1:0] rptr_r;
    logic [ADDR_W:0]   count_r;
    logic              do_push_s;
    logic              do_pop_s;

    // A write while full is dropped even when a pop frees a slot this cycle.
    assign full      = (count_r == (ADDR_W+1)'(DEPTH));
    assign not_empty = (count_r != (ADDR_W+1)'(0));
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && not_empty;
    assign count     = count_r;
    assign rdata     = mem_r[rptr_r];

    // Storage write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wptr_r] <= wdata;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + ADDR_W'(1);
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + ADDR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (ADDR_W+1)'(1);
                2'b01:   count_r <= count_r - (ADDR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/expr_char_fifo.sv
// Character feeder for the expression recognizer: FIFO, head classifier,
// parenthesis nesting tracker and sticky error. Option macro: SKIP_SPACE_EN.
module expr_char_fifo
    import expr_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int MAX_NEST = 7,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int NW      = $clog2(MAX_NEST + 1)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    input  logic              rd_en,
    output logic              out_valid,
    output logic [7:0]        out_char,
    output logic [2:0]        out_class,
    output logic [NW-1:0]     depth,
    output logic [ADDR_W:0]   count,
    output logic              err
);

    logic          push_s;
    logic          pop_s;
    logic [NW-1:0] depth_r;
    logic          err_r;

    // Write-port filter: optionally drop whitespace before it is stored.
    always_comb begin
`ifdef SKIP_SPACE_EN
        if ((wr_data == ASCII_SPACE) || (wr_data == ASCII_TAB)) begin
            push_s = 1'b0;
        end else begin
            push_s = wr_en;
        end
`else
        push_s = wr_en;
`endif
    end

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk       (clk),
        .clr       (clr),
        .push      (push_s),
        .wdata     (wr_data),
        .pop       (rd_en),
        .rdata     (out_char),
        .count     (count),
        .full      (full),
        .not_empty (out_valid)
    );

    assign pop_s     = rd_en && out_valid;
    assign out_class = classify(out_char);
    assign depth     = depth_r;
    assign err       = err_r;

    // Nesting and sticky error, updated only when the head is consumed.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            depth_r <= '0;
            err_r   <= 1'b0;
        end else if (pop_s) begin
            case (out_class)
                CLS_LPAR: begin
                    if (depth_r == NW'(MAX_NEST)) begin
                        err_r <= 1'b1;
                    end else begin
                        depth_r <= depth_r + NW'(1);
                    end
                end
                CLS_RPAR: begin
                    if (depth_r == NW'(0)) begin
                        err_r <= 1'b1;
                    end else begin
                        depth_r <= depth_r - NW'(1);
                    end
                end
                CLS_OTHER: err_r <= 1'b1;
                default:   depth_r <= depth_r;
            endcase
        end else begin
            depth_r <= depth_r;
        end
    end

endmodule

// File: tb/tb_expr_char_fifo.sv
// Directed self-checking bench for expr_char_fifo (default DEPTH=8, MAX_NEST=7).
module tb_expr_char_fifo;

    logic       clk = 1'b0;
    logic       clr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic       full;
    logic       out_valid;
    logic [7:0] out_char;
    logic [2:0] out_class;
    logic [2:0] depth;
    logic [3:0] count;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    expr_char_fifo dut (
        .clk       (clk),
        .clr       (clr),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .rd_en     (rd_en),
        .out_valid (out_valid),
        .out_char  (out_char),
        .out_class (out_class),
        .depth     (depth),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic do_clr;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b1;
        #2;
        clr   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic write_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            wr_en   = 1'b1;
            wr_data = s[i];
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic pop1;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        clr = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
        #3;
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", count); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %b want 0", full); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        n_cmp++; if (depth !== 3'd0) begin n_bad++; $display("FAIL rst_depth: got %0d want 0", depth); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
        clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_expr;
        string      s = "(1+2)";
        logic [2:0] ecls [5] = '{3'd3, 3'd0, 3'd1, 3'd0, 3'd4};
        logic [2:0] edep [5] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
        do_clr();
        write_str(s);
        n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL t1_count: got %0d want 5", count); end
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (out_char !== s[i]) begin n_bad++; $display("FAIL t1_char%0d: got %h want %h", i, out_char, s[i]); end
            n_cmp++; if (out_class !== ecls[i]) begin n_bad++; $display("FAIL t1_class%0d: got %0d want %0d", i, out_class, ecls[i]); end
            @(posedge clk);
            #1;
            n_cmp++; if (depth !== edep[i]) begin n_bad++; $display("FAIL t1_depth%0d: got %0d want %0d", i, depth, edep[i]); end
        end
        rd_en = 1'b0;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL t1_err: got %b want 0", err); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL t1_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_full;
        string s = "123456789";
        do_clr();
        write_str(s.substr(0, 6));
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL t2_full7: got %b want 0", full); end
        write_str(s.substr(7, 7));
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL t2_full8: got %b want 1", full); end
        write_str(s.substr(8, 8));
        n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL t2_count: got %0d want 8", count); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (out_char !== s[i]) begin n_bad++; $display("FAIL t2_char%0d: got %h want %h", i, out_char, s[i]); end
            pop1();
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL t2_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_full_push_pop;
        string s = "01234567";
        do_clr();
        write_str(s);
        wr_en = 1'b1; wr_data = 8'h39; rd_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
        n_cmp++; if (count !== 4'd7) begin n_bad++; $display("FAIL t3_count: got %0d want 7", count); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL t3_full: got %b want 0", full); end
        for (int i = 1; i < 8; i++) begin
            n_cmp++; if (out_char !== s[i]) begin n_bad++; $display("FAIL t3_char%0d: got %h want %h", i, out_char, s[i]); end
            pop1();
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL t3_empty: got %b want 0", out_valid); end
        // Push and pop on an empty FIFO: only the push takes effect.
        wr_en = 1'b1; wr_data = 8'h2A; rd_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
        n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL t3_emptypp: got %0d want 1", count); end
        n_cmp++; if (out_class !== 3'd2) begin n_bad++; $display("FAIL t3_mulcls: got %0d want 2", out_class); end
    endtask

    task automatic test_underflow;
        do_clr();
        write_str(")((");
        pop1();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL t4_err: got %b want 1", err); end
        n_cmp++; if (depth !== 3'd0) begin n_bad++; $display("FAIL t4_depth0: got %0d want 0", depth); end
        pop1();
        pop1();
        n_cmp++; if (depth !== 3'd2) begin n_bad++; $display("FAIL t4_depth2: got %0d want 2", depth); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL t4_sticky: got %b want 1", err); end
    endtask

    task automatic test_overflow_clr;
        do_clr();
        write_str("((((((((");
        for (int i = 0; i < 7; i++) pop1();
        n_cmp++; if (depth !== 3'd7) begin n_bad++; $display("FAIL t5_depth7: got %0d want 7", depth); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL t5_err7: got %b want 0", err); end
        pop1();
        n_cmp++; if (depth !== 3'd7) begin n_bad++; $display("FAIL t5_depth8: got %0d want 7", depth); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL t5_err8: got %b want 1", err); end
        write_str("(((");
        #2;
        clr = 1'b1;
        #1;
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL t5_clr_count: got %0d want 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL t5_clr_valid: got %b want 0", out_valid); end
        n_cmp++; if (depth !== 3'd0) begin n_bad++; $display("FAIL t5_clr_depth: got %0d want 0", depth); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL t5_clr_err: got %b want 0", err); end
        clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_space;
        do_clr();
        write_str("1 + 2");
`ifdef SKIP_SPACE_EN
        n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL t6_count: got %0d want 3", count); end
        n_cmp++; if (out_char !== 8'h31) begin n_bad++; $display("FAIL t6_c0: got %h want 31", out_char); end
        pop1();
        n_cmp++; if (out_char !== 8'h2B) begin n_bad++; $display("FAIL t6_c1: got %h want 2b", out_char); end
        pop1();
        n_cmp++; if (out_char !== 8'h32) begin n_bad++; $display("FAIL t6_c2: got %h want 32", out_char); end
        pop1();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL t6_err: got %b want 0", err); end
`else
        n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL t6_count: got %0d want 5", count); end
        pop1();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL t6_err1: got %b want 0", err); end
        n_cmp++; if (out_class !== 3'd7) begin n_bad++; $display("FAIL t6_spcls: got %0d want 7", out_class); end
        pop1();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL t6_err2: got %b want 1", err); end
`endif
    endtask

    initial begin
        test_reset();
        test_expr();
        test_full();
        test_full_push_pop();
        test_underflow();
        test_overflow_clr();
        test_space();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
